// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 burst slave serving INCR read/write bursts from a single-port synchronous SRAM.
// Optional SRAM_SLV_ERR_EN: unaligned or non-INCR bursts are sequenced without SRAM access and answered SLVERR.
module axi_sram_slave #(
  parameter int SRAM_AW = 14,
  parameter int MAX_LEN = 16,
  parameter int ID_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [ID_W-1:0]    awid,
  input  logic [31:0]        awaddr,
  input  logic [3:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [1:0]         awburst,
  input  logic               awvalid,
  output logic               awready,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  output logic [ID_W-1:0]    bid,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready,
  input  logic [ID_W-1:0]    arid,
  input  logic [31:0]        araddr,
  input  logic [3:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  input  logic               arvalid,
  output logic               arready,
  output logic [ID_W-1:0]    rid,
  output logic [31:0]        rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  output logic               sram_cs,
  output logic               sram_oe,
  output logic [3:0]         sram_web,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [31:0]        sram_di,
  input  logic [31:0]        sram_do
);
  localparam int CW = $clog2(MAX_LEN);
  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;
  state_t state;
  logic [SRAM_AW-1:0] addr;
  logic [CW-1:0] beat, len;
  logic [31:0] rd_hold;
  logic err, rd_fresh;
  logic aw_hs, ar_hs, w_hs, r_hs, b_hs, last, rd_issue, wr_issue, aw_err, ar_err;
  logic unused_ok;
  assign unused_ok = ^{awsize, arsize, wlast, awburst, arburst, awaddr[31:SRAM_AW+2], awaddr[1:0],
                       araddr[31:SRAM_AW+2], araddr[1:0]};
`ifdef SRAM_SLV_ERR_EN
  assign aw_err = awaddr[1:0] != 2'b00 || awburst != 2'b01;
  assign ar_err = araddr[1:0] != 2'b00 || arburst != 2'b01;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif
  // readies are gated by rstn so they read 0 while reset is held
  assign awready = rstn && state == IDLE;
  assign arready = rstn && state == IDLE && !awvalid;
  assign wready = state == WR;
  assign aw_hs = awvalid && awready;
  assign ar_hs = arvalid && arready;
  assign w_hs = wvalid && wready;
  assign r_hs = rvalid && rready;
  assign b_hs = bvalid && bready;
  assign last = beat == len;
  assign rlast = rvalid && last;
  assign rd_issue = (ar_hs && !ar_err) || (r_hs && !last && !err);
  assign wr_issue = w_hs && !err;
  assign sram_cs = rd_issue || wr_issue;
  assign sram_oe = rd_issue;
  assign sram_web = wr_issue ? ~wstrb : 4'hF;
  assign sram_di = wr_issue ? wdata : '0;
  assign sram_a = ar_hs ? araddr[SRAM_AW+1:2] : (rd_issue ? addr + SRAM_AW'(1) : addr);
  // SRAM output is only trusted the cycle after a read; a stalled beat is replayed from rd_hold
  assign rdata = err ? '0 : (rd_fresh ? sram_do : rd_hold);
  assign rresp = (rvalid && err) ? 2'b10 : 2'b00;
  assign bresp = (bvalid && err) ? 2'b10 : 2'b00;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      addr <= '0;
      beat <= '0;
      len <= '0;
      err <= 1'b0;
      rd_fresh <= 1'b0;
      rd_hold <= '0;
      rvalid <= 1'b0;
      bvalid <= 1'b0;
      rid <= '0;
      bid <= '0;
    end else begin
      rd_fresh <= rd_issue;
      rd_hold <= rdata;
      case (state)
        IDLE:
          if (aw_hs) begin
            state <= WR;
            bid <= awid;
            addr <= awaddr[SRAM_AW+1:2];
            len <= CW'(awlen);
            beat <= '0;
            err <= aw_err;
          end else if (ar_hs) begin
            state <= RD;
            rid <= arid;
            addr <= araddr[SRAM_AW+1:2];
            len <= CW'(arlen);
            beat <= '0;
            err <= ar_err;
            rvalid <= 1'b1;
          end
        RD:
          if (r_hs) begin
            addr <= addr + SRAM_AW'(1);
            beat <= beat + CW'(1);
            if (last) begin
              state <= IDLE;
              rvalid <= 1'b0;
            end
          end
        WR:
          if (w_hs) begin
            addr <= addr + SRAM_AW'(1);
            beat <= beat + CW'(1);
            if (last) begin
              state <= WRESP;
              bvalid <= 1'b1;
            end
          end
        WRESP:
          if (b_hs) begin
            state <= IDLE;
            bvalid <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: random AXI bursts against a word-array memory model with byte-strobe merging.
module tb_axi_sram_slave;
  logic clk = 0, rstn;
  logic [3:0] awid, arid, bid, rid, awlen, arlen, wstrb, sram_web;
  logic [31:0] awaddr, araddr, wdata, rdata, sram_di, sram_do;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready, sram_cs, sram_oe;
  logic [13:0] sram_a;
  logic [31:0] sram [16384];
  logic [31:0] ref_mem [16384];
  logic [31:0] wd [16];
  logic [3:0] ws [16];
  int n_chk = 0, n_err = 0, cs_cnt = 0;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .rstn(rstn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] web);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (!web[b]) r[8*b+:8] = d[8*b+:8];
    return r;
  endfunction

  // synchronous SRAM macro: registered read data, per-byte active-low write enables
  always @(posedge clk) begin
    if (sram_cs && !sram_oe) sram[sram_a] <= merge(sram[sram_a], sram_di, sram_web);
    if (sram_cs && sram_oe) sram_do <= sram[sram_a];
    if (sram_cs) cs_cnt <= cs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] a, input int n, input int bstall, input bit ar_too);
    int t;
    logic [13:0] w;
    logic [3:0] nw;
    @(posedge clk); #1;
    awid = id; awaddr = a; awlen = 4'(n - 1); awburst = 2'b01; awsize = 3'd2; awvalid = 1;
    if (ar_too) begin
      arid = id; araddr = a; arlen = 4'd0; arburst = 2'b01; arsize = 3'd2; arvalid = 1;
    end
    @(negedge clk);
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    check("awready", 32'(awready), 32'd1);
    if (ar_too) check("ar_blocked", 32'(arready), 32'd0);
    @(posedge clk); #1 awvalid = 0;
    for (int i = 0; i < n; i++) begin
      w = 14'((a >> 2) + 32'(i));
      nw = ~ws[i];
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == n - 1);
      @(negedge clk);
      check("wready", 32'(wready), 32'd1);
      check("sram_a_wr", 32'(sram_a), 32'(w));
      check("sram_web_wr", 32'(sram_web), 32'(nw));
      if (ar_too) check("ar_wait_w", 32'(arready), 32'd0);
      for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[w][8*b+:8] = wd[i][8*b+:8];
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
    for (int i = 0; i < bstall; i++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(bvalid), 32'd1);
      if (ar_too) check("ar_wait_b", 32'(arready), 32'd0);
      @(posedge clk); #1;
    end
    bready = 1;
    @(negedge clk);
    check("bvalid", 32'(bvalid), 32'd1);
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1 bready = 0;
    if (ar_too) arvalid = 0;
    @(negedge clk);
    check("bvalid_clr", 32'(bvalid), 32'd0);
    if (ar_too) check("ar_ready_after_b", 32'(arready), 32'd1);
  endtask

  // mode 0: rready always 1, mode 1: pattern 1,0,0 repeating, mode 2: random
  task automatic axi_read(input logic [3:0] id, input logic [31:0] a, input int n, input int mode, input bit slverr);
    int t, beat, cyc;
    logic [31:0] want;
    @(posedge clk); #1;
    arid = id; araddr = a; arlen = 4'(n - 1); arburst = 2'b01; arsize = 3'd2; arvalid = 1;
    @(negedge clk);
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    check("arready", 32'(arready), 32'd1);
    check("sram_cs_ar", 32'(sram_cs), slverr ? 32'd0 : 32'd1);
    if (!slverr) check("sram_a_ar", 32'(sram_a), 32'(14'(a >> 2)));
    @(posedge clk); #1 arvalid = 0;
    beat = 0; cyc = 0;
    while (beat < n && cyc < 200) begin
      rready = mode == 0 ? 1'b1 : (mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (cyc == 0) check("rvalid_lat", 32'(rvalid), 32'd1);
      if (rvalid) begin
        want = slverr ? 32'd0 : ref_mem[14'((a >> 2) + 32'(beat))];
        check("rdata", rdata, want);
        check("rid", 32'(rid), 32'(id));
        check("rlast", 32'(rlast), 32'(beat == n - 1));
        check("rresp", 32'(rresp), slverr ? 32'd2 : 32'd0);
        check("web_rd", 32'(sram_web), 32'hF);
        if (rready) beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 0;
    check("r_beats", 32'(beat), 32'(n));
    if (mode == 0) check("r_cycles", 32'(cyc), 32'(n));
    @(negedge clk);
    check("rvalid_end", 32'(rvalid), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    for (int i = 0; i < 16384; i++) begin sram[i] = 0; ref_mem[i] = 0; end
    rstn = 0;
    {awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_cs", 32'(sram_cs), 32'd0);
    check("rst_web", 32'(sram_web), 32'hF);
    check("rst_a", 32'(sram_a), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    @(posedge clk); #1 rstn = 1;

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(4'd3, 32'h10, 1, 0, 0);
    axi_read(4'd3, 32'h10, 1, 0, 0);

    for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
    axi_write(4'd1, 32'h100, 16, 0, 0);
    axi_read(4'd2, 32'h100, 16, 0, 0);
    axi_read(4'd4, 32'h100, 4, 1, 0);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    axi_write(4'd5, 32'h300, 1, 1, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    axi_write(4'd5, 32'h300, 1, 0, 0);
    axi_read(4'd5, 32'h300, 1, 0, 0);

    wd[0] = 32'h5555AAAA; ws[0] = 4'hF;
    axi_write(4'd6, 32'h400, 1, 3, 1);
    axi_read(4'd6, 32'h400, 1, 0, 0);

    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(4'd7, 32'h200, 8, 0, 0);
    @(posedge clk); #1;
    arid = 4'd9; araddr = 32'h200; arlen = 4'd7; arburst = 2'b01; arvalid = 1;
    @(negedge clk);
    check("rst_test_arready", 32'(arready), 32'd1);
    @(posedge clk); #1 arvalid = 0; rready = 1;
    repeat (3) @(posedge clk);
    #1 rstn = 0;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_rlast", 32'(rlast), 32'd0);
    check("midrst_arready", 32'(arready), 32'd0);
    check("midrst_cs", 32'(sram_cs), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_rid", 32'(rid), 32'd0);
    @(posedge clk); #1 rstn = 1; rready = 0;
    axi_read(4'd9, 32'h200, 8, 2, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(4'd10, 32'hFFF8, 4, 0, 0);
    axi_read(4'd11, 32'hFFF8, 4, 0, 0);

    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(1, 16);
      a = {16'd0, 14'($urandom_range(0, 16383)), 2'b00};
      for (int i = 0; i < n; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      axi_write(4'($urandom_range(0, 15)), a, n, $urandom_range(0, 2), 0);
      axi_read(4'($urandom_range(0, 15)), a, n, 2, 0);
      if (k % 4 == 0) axi_read(4'($urandom_range(0, 15)), {16'd0, 14'($urandom_range(0, 16383)), 2'b00},
                               $urandom_range(1, 16), $urandom_range(0, 2), 0);
    end

`ifdef SRAM_SLV_ERR_EN
    begin
      int cs0;
      cs0 = cs_cnt;
      axi_read(4'd12, 32'h102, 2, 0, 1);
      check("err_no_cs", 32'(cs_cnt - cs0), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion within budget");
    $fatal(1, "timeout");
  end
endmodule
